// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: select encodings, FSM states
// and the command-to-response latency helper.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HI1,
    S_LO1,
    S_HI2,
    S_LO2,
    S_RESP
  } seq_state_e;

  // Cycles from the accept edge to the first cycle with rsp_valid high.
  function automatic int alu_seq_latency(input int settle, input int en_high, input int en_low);
    return settle + 2 * (en_high + en_low) + 1;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU-pin and response bundle between the sequencer (slave)
// and its environment: command source, ALU and response consumer (master).
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_x;
  logic [1:0] cmd_y;
  logic [1:0] cmd_sel;
  logic [1:0] alu_x;
  logic [1:0] alu_y;
  logic [1:0] alu_sel;
  logic       alu_enable;
  logic [3:0] alu_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_z;
  logic [1:0] rsp_sel;
  logic       rsp_err;
  logic [7:0] ops_done;
  logic [7:0] err_cnt;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_sel, alu_z, rsp_ready,
    output cmd_ready, alu_x, alu_y, alu_sel, alu_enable,
           rsp_valid, rsp_z, rsp_sel, rsp_err, ops_done, err_cnt
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_sel, alu_z, rsp_ready,
    input  cmd_ready, alu_x, alu_y, alu_sel, alu_enable,
           rsp_valid, rsp_z, rsp_sel, rsp_err, ops_done, err_cnt
  );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden result of the 2-bit four-function ALU.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  input  logic [1:0] i_sel,
  output logic [3:0] o_z
);

  always_comb begin
    o_z = '0;
    case (i_sel)
      OP_ADD:  o_z = {1'b0, ({1'b0, i_x} + {1'b0, i_y})};
      OP_MUL:  o_z = {2'b00, i_x} * {2'b00, i_y};
      OP_AND:  o_z = {2'b00, i_x & i_y};
      default: o_z = {2'b00, i_x | i_y};
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives one ALU operation per command with a two-pulse enable sequence,
// captures and checks the result, and returns it over a valid/ready port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE  = 1,
  parameter int EN_HIGH = 1,
  parameter int EN_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus
);

  localparam int CW = 16;

  seq_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_ready;
  logic          r_alu_enable;
  logic [1:0]    r_alu_x, r_alu_y, r_alu_sel;
  logic          r_rsp_valid;
  logic [3:0]    r_rsp_z;
  logic [1:0]    r_rsp_sel;
  logic          r_rsp_err;
  logic [7:0]    r_ops_done, r_err_cnt;
  logic [3:0]    w_ref_z;
  logic          w_phase_end;

  alu_ref_model u_ref (
    .i_x   (r_alu_x),
    .i_y   (r_alu_y),
    .i_sel (r_alu_sel),
    .o_z   (w_ref_z)
  );

  assign w_phase_end = (r_cnt == '0);

  // Every timed phase counts r_cnt down to zero, then reloads for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmd_ready  <= 1'b1;
      r_alu_enable <= 1'b0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_z      <= '0;
      r_rsp_sel    <= '0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= '0;
      r_err_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_alu_x     <= bus.cmd_x;
            r_alu_y     <= bus.cmd_y;
            r_alu_sel   <= bus.cmd_sel;
            r_cmd_ready <= 1'b0;
            r_cnt       <= CW'(SETTLE - 1);
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_phase_end) begin
            r_alu_enable <= 1'b1;
            r_cnt        <= CW'(EN_HIGH - 1);
            r_state      <= S_HI1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_HI1: begin
          if (w_phase_end) begin
            r_alu_enable <= 1'b0;
            r_cnt        <= CW'(EN_LOW - 1);
            r_state      <= S_LO1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_LO1: begin
          if (w_phase_end) begin
            r_alu_enable <= 1'b1;
            r_cnt        <= CW'(EN_HIGH - 1);
            r_state      <= S_HI2;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_HI2: begin
          if (w_phase_end) begin
            r_alu_enable <= 1'b0;
            r_cnt        <= CW'(EN_LOW - 1);
            r_state      <= S_LO2;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_LO2: begin
          // Z now holds the result registered on the first pulse.
          if (w_phase_end) begin
            r_rsp_z     <= bus.alu_z;
            r_rsp_sel   <= r_alu_sel;
            r_rsp_err   <= (bus.alu_z != w_ref_z);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 8'd1;
            if (r_rsp_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_alu_enable <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.alu_x      = r_alu_x;
  assign bus.alu_y      = r_alu_y;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.alu_enable = r_alu_enable;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_z      = r_rsp_z;
  assign bus.rsp_sel    = r_rsp_sel;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.ops_done   = r_ops_done;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: two sequencers (default and stretched timing) each driving a
// behavioural two-register ALU; table, directed and random checks.
module tb_alu_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [1:0] x, y, sel;
    int         hold;
    logic [3:0] z;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if b1();
  alu_sequencer_if b2();

  alu_sequencer u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_sequencer #(.SETTLE(2), .EN_HIGH(2), .EN_LOW(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int n_cmp = 0;
  int n_bad = 0;
  int m_ops = 0;
  int m_errs = 0;
  logic alu_fault = 1'b0;

  // ALU behaviour: plain integer arithmetic truncated to the 4-bit Z bus.
  function automatic logic [3:0] alu_fn(input logic [1:0] x, input logic [1:0] y, input logic [1:0] sel);
    int a, b, r;
    a = int'(x);
    b = int'(y);
    case (sel)
      2'd0:    r = a + b;
      2'd1:    r = a * b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return 4'(r);
  endfunction

  // ALU: Z takes the old function register on each enable rise.
  logic [3:0] a1_reg, a1_z, a2_reg, a2_z;
  always @(posedge b1.alu_enable) begin
    a1_z   <= a1_reg;
    a1_reg <= alu_fn(b1.alu_x, b1.alu_y, b1.alu_sel);
  end
  always @(posedge b2.alu_enable) begin
    a2_z   <= a2_reg;
    a2_reg <= alu_fn(b2.alu_x, b2.alu_y, b2.alu_sel);
  end
  assign b1.alu_z = alu_fault ? 4'h0 : a1_z;
  assign b2.alu_z = a2_z;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command on DUT1; called at a sample point with DUT1 idle.
  task automatic do_op(input logic [1:0] x, input logic [1:0] y, input logic [1:0] sel,
                       input int hold, input bit poke, output logic [3:0] z_out);
    int en1, en2, rv;
    logic prev;
    logic [3:0] ez;
    logic ee;
    ez = alu_fault ? 4'h0 : alu_fn(x, y, sel);
    ee = (ez != alu_fn(x, y, sel));
    z_out = 4'hF;
    chk("idle_ready", b1.cmd_ready, 1);
    b1.cmd_x = x; b1.cmd_y = y; b1.cmd_sel = sel; b1.cmd_valid = 1'b1;
    b1.rsp_ready = 1'b0;
    tick();
    b1.cmd_valid = 1'b0;
    chk("busy_ready", b1.cmd_ready, 0);
    chk("alu_x", b1.alu_x, x);
    chk("alu_y", b1.alu_y, y);
    chk("alu_sel", b1.alu_sel, sel);
    prev = 1'b0; en1 = -1; en2 = -1; rv = -1;
    for (int c = 1; c <= 60; c++) begin
      if (b1.alu_enable && !prev) begin
        if (en1 < 0) en1 = c;
        else if (en2 < 0) en2 = c;
      end
      prev = b1.alu_enable;
      if (b1.rsp_valid) begin rv = c; break; end
      tick();
    end
    if (rv < 0) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("en_rise1", en1, 2);
    chk("en_rise2", en2, 4);
    chk("rsp_cycle", rv, 6);
    chk("rsp_z", b1.rsp_z, ez);
    chk("rsp_sel", b1.rsp_sel, sel);
    chk("rsp_err", b1.rsp_err, ee);
    z_out = b1.rsp_z;
    if (poke) begin
      b1.cmd_x = 2'd0; b1.cmd_y = 2'd0; b1.cmd_sel = OP_ADD; b1.cmd_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", b1.rsp_valid, 1);
      chk("hold_z", b1.rsp_z, ez);
      chk("hold_sel", b1.rsp_sel, sel);
      chk("hold_err", b1.rsp_err, ee);
      chk("hold_cmd_ready", b1.cmd_ready, 0);
    end
    b1.rsp_ready = 1'b1;
    tick();
    b1.rsp_ready = 1'b0;
    b1.cmd_valid = 1'b0;
    m_ops = (m_ops + 1) % 256;
    if (ee) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
    chk("post_ready", b1.cmd_ready, 1);
    chk("post_valid", b1.rsp_valid, 0);
    chk("ops_done", b1.ops_done, m_ops);
    chk("err_cnt", b1.err_cnt, m_errs);
    if (poke) begin
      tick();
      chk("poke_ignored_x", b1.alu_x, x);
      chk("poke_ready", b1.cmd_ready, 1);
    end
  endtask

  vec_t tbl[6];
  vec_t bb[4];
  logic [3:0] zq[$];

  initial begin
    logic [3:0] z;
    int en1, en2, rv, nsent;
    logic prev;
    bit seen;

    tbl[0] = '{x: 2'd3, y: 2'd3, sel: OP_ADD, hold: 0, z: 4'd6};
    tbl[1] = '{x: 2'd3, y: 2'd3, sel: OP_MUL, hold: 2, z: 4'd9};
    tbl[2] = '{x: 2'd2, y: 2'd1, sel: OP_AND, hold: 1, z: 4'd0};
    tbl[3] = '{x: 2'd0, y: 2'd3, sel: OP_OR,  hold: 0, z: 4'd3};
    tbl[4] = '{x: 2'd2, y: 2'd2, sel: OP_MUL, hold: 3, z: 4'd4};
    tbl[5] = '{x: 2'd3, y: 2'd2, sel: OP_AND, hold: 0, z: 4'd2};
    bb[0]  = '{x: 2'd3, y: 2'd1, sel: OP_ADD, hold: 0, z: 4'b0100};
    bb[1]  = '{x: 2'd3, y: 2'd1, sel: OP_MUL, hold: 0, z: 4'b0011};
    bb[2]  = '{x: 2'd3, y: 2'd1, sel: OP_AND, hold: 0, z: 4'b0001};
    bb[3]  = '{x: 2'd3, y: 2'd1, sel: OP_OR,  hold: 0, z: 4'b0011};

    b1.cmd_valid = 0; b1.cmd_x = 0; b1.cmd_y = 0; b1.cmd_sel = 0; b1.rsp_ready = 0;
    b2.cmd_valid = 0; b2.cmd_x = 0; b2.cmd_y = 0; b2.cmd_sel = 0; b2.rsp_ready = 1;

    tick(); tick();
    chk("rst_cmd_ready", b1.cmd_ready, 1);
    chk("rst_enable", b1.alu_enable, 0);
    chk("rst_rsp_valid", b1.rsp_valid, 0);
    chk("rst_alu_x", b1.alu_x, 0);
    chk("rst_rsp_z", b1.rsp_z, 0);
    chk("rst_ops_done", b1.ops_done, 0);
    chk("rst_err_cnt", b1.err_cnt, 0);
    rst_n = 1'b1;
    tick();

    // add 3+2, then mul 3x3 with a stalled consumer and a command poked in RESP
    do_op(2'd3, 2'd2, OP_ADD, 0, 1'b0, z);
    chk("add_3_2", z, 4'b0101);
    do_op(2'd3, 2'd3, OP_MUL, 5, 1'b1, z);
    chk("mul_3_3", z, 4'b1001);

    // stuck-at-zero ALU, then a healthy one
    alu_fault = 1'b1;
    do_op(2'd2, 2'd1, OP_OR, 0, 1'b0, z);
    chk("fault_z", z, 0);
    chk("fault_err_cnt", b1.err_cnt, 1);
    alu_fault = 1'b0;
    do_op(2'd0, 2'd0, OP_ADD, 0, 1'b0, z);
    chk("recover_err", b1.rsp_err, 0);
    chk("recover_err_cnt", b1.err_cnt, 1);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].x, tbl[i].y, tbl[i].sel, tbl[i].hold, 1'b0, z);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
    end

    // reset pulse in the middle of the second enable pulse
    b1.cmd_x = 2'd3; b1.cmd_y = 2'd2; b1.cmd_sel = OP_MUL; b1.cmd_valid = 1'b1;
    tick();
    b1.cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("hi2_enable", b1.alu_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_enable", b1.alu_enable, 0);
    chk("async_rst_ready", b1.cmd_ready, 1);
    chk("async_rst_valid", b1.rsp_valid, 0);
    chk("async_rst_ops", b1.ops_done, 0);
    #2 rst_n = 1'b1;
    m_ops = 0; m_errs = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b1.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", seen, 0);
    do_op(2'd1, 2'd1, OP_ADD, 0, 1'b0, z);
    chk("add_1_1", z, 4'b0010);

    // back-to-back with cmd_valid and rsp_ready held high
    b1.rsp_ready = 1'b1; b1.cmd_valid = 1'b1; nsent = 0;
    for (int c = 0; c < 200 && zq.size() < 4; c++) begin
      if (b1.rsp_valid) zq.push_back(b1.rsp_z);
      if (b1.cmd_ready) begin
        if (nsent < 4) begin
          b1.cmd_x = bb[nsent].x; b1.cmd_y = bb[nsent].y; b1.cmd_sel = bb[nsent].sel;
          nsent++;
        end else b1.cmd_valid = 1'b0;
      end
      tick();
    end
    b1.cmd_valid = 1'b0; b1.rsp_ready = 1'b0;
    chk("b2b_count", zq.size(), 4);
    for (int i = 0; i < zq.size() && i < 4; i++) chk($sformatf("b2b_z%0d", i), zq[i], bb[i].z);
    m_ops = (m_ops + 4) % 256;
    chk("b2b_ops_done", b1.ops_done, m_ops);
    chk("b2b_err_cnt", b1.err_cnt, m_errs);
    tick();

    // random operands, random faults and consumer stalls
    for (int i = 0; i < 40; i++) begin
      alu_fault = ($urandom_range(0, 3) == 0);
      do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), 1'b0, z);
    end
    // drive err_cnt into saturation and ops_done through its wrap
    alu_fault = 1'b1;
    for (int i = 0; i < 260; i++)
      do_op(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), OP_OR, 0, 1'b0, z);
    chk("err_cnt_sat", b1.err_cnt, 255);
    alu_fault = 1'b0;

    // stretched timing: SETTLE=2, EN_HIGH=2, EN_LOW=3
    chk("d2_ready", b2.cmd_ready, 1);
    b2.cmd_x = 2'd1; b2.cmd_y = 2'd2; b2.cmd_sel = OP_MUL; b2.cmd_valid = 1'b1;
    tick();
    b2.cmd_valid = 1'b0;
    prev = 1'b0; en1 = -1; en2 = -1; rv = -1;
    for (int c = 1; c <= 60; c++) begin
      if (b2.alu_enable && !prev) begin
        if (en1 < 0) en1 = c;
        else if (en2 < 0) en2 = c;
      end
      prev = b2.alu_enable;
      if (b2.rsp_valid) begin rv = c; break; end
      tick();
    end
    chk("d2_en_rise1", en1, 3);
    chk("d2_en_rise2", en2, 8);
    chk("d2_rsp_cycle", rv, 13);
    chk("d2_rsp_z", b2.rsp_z, 2);
    chk("d2_rsp_err", b2.rsp_err, 0);
    tick();
    chk("d2_ops_done", b2.ops_done, 1);
    chk("d2_ready_after", b2.cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
